// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data requests onto a single
// variable-latency memory port. It also formats RV32 loads, steers store byte
// lanes and rejects misaligned or illegal data accesses without touching memory.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT, D_ERR} state_t;

    state_t      state;
    logic [3:0]  streak;     // consecutive data grants while a fetch waits
    logic        d_store;    // in-flight data access is a store
    logic [2:0]  d_f3;       // funct3 of the in-flight data access
    logic [1:0]  d_lane;     // byte lane of the in-flight data access

    logic        in_idle;
    logic        if_first;
    logic [1:0]  d_size;
    logic        f3_illegal;
    logic        misaligned;
    logic        d_legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Arbitration: data wins unless the fetch has been starved long enough.
    assign in_idle  = (state == IDLE) && !rst;
    assign if_first = if_req && (streak == STREAK_MAX);
    assign if_gnt   = in_idle && if_req && (!d_req || if_first);
    assign d_gnt    = in_idle && d_req && !if_first;

    // Access legality: funct3[1:0] encodes the size (byte, half, word).
    assign d_size     = d_funct3[1:0];
    assign f3_illegal = (d_funct3 == 3'd3) || (d_funct3[2:1] == 2'b11);
    assign misaligned = ((d_size == 2'd1) && d_addr[0]) ||
                        ((d_size == 2'd2) && (d_addr[1:0] != 2'b00));
    assign d_legal    = !f3_illegal && !misaligned;

    // Store steering: narrow data is replicated so every enabled lane sees it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        st_be    = 4'b1111;
        st_wdata = d_wdata;
        case (d_size)
            2'd0: begin
                st_be    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting of the returned word using the captured funct3 and lane.
    always_comb begin
        ld_byte = m_rdata[7:0];
        case (d_lane)
            2'd1:    ld_byte = m_rdata[15:8];
            2'd2:    ld_byte = m_rdata[23:16];
            2'd3:    ld_byte = m_rdata[31:24];
            default: ld_byte = m_rdata[7:0];
        endcase
        ld_half = d_lane[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (d_f3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = m_rdata;
        endcase
    end

    // Control FSM, streak counter, memory port and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= 4'd0;
            d_store   <= 1'b0;
            d_f3      <= 3'd0;
            d_lane    <= 2'd0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'd0;
            d_err     <= 1'b0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_be      <= 4'd0;
            m_addr    <= 32'd0;
            m_wdata   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order in this block.
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_gnt || !if_req) begin
                        streak <= 4'd0;
                    end else if (d_gnt && (streak != STREAK_MAX)) begin
                        streak <= streak + 4'd1;
                    end
                    if (if_gnt) begin
                        state   <= I_WAIT;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_be    <= 4'b1111;
                        m_addr  <= if_addr & 32'hFFFF_FFFC;
                        m_wdata <= 32'd0;
                    end else if (d_gnt) begin
                        if (d_legal) begin
                            state   <= D_WAIT;
                            m_req   <= 1'b1;
                            m_we    <= d_we;
                            m_be    <= d_we ? st_be : 4'b1111;
                            m_addr  <= d_addr & 32'hFFFF_FFFC;
                            m_wdata <= d_we ? st_wdata : 32'd0;
                            d_store <= d_we;
                            d_f3    <= d_funct3;
                            d_lane  <= d_addr[1:0];
                        end else begin
                            // Illegal access completes next cycle, no memory op.
                            state    <= D_ERR;
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= 32'd0;
                        end
                    end
                end
                I_WAIT: begin
                    if (m_ack) begin
                        state     <= IDLE;
                        m_req     <= 1'b0;
                        if_rvalid <= 1'b1;
                        if_rdata  <= m_rdata;
                    end
                end
                D_WAIT: begin
                    if (m_ack) begin
                        state    <= IDLE;
                        m_req    <= 1'b0;
                        d_rvalid <= 1'b1;
                        d_rdata  <= d_store ? 32'd0 : ld_data;
                    end
                end
                D_ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, all
// checked against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: what the arbiter owes the outside world.
    bit          ref_busy;      // a memory transaction is outstanding
    bit          ref_err_cyc;   // the error-completion cycle is in progress
    int          ref_streak;
    bit          exp_fetch;
    bit          exp_store;
    logic [2:0]  exp_f3;
    logic [31:0] exp_addr;
    logic [31:0] exp_m_addr;
    logic [3:0]  exp_m_be;
    bit          exp_m_we;
    logic [31:0] exp_m_wdata;
    bit          resp_if, resp_d, resp_err;
    logic [31:0] resp_data;
    bit          last_if_gnt, last_d_gnt;
    logic        obs_d_gnt;
    bit          gq[$];         // grant order, 1 = fetch

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        int s = int'(f3) % 4;
        return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (addr % 32'(ref_size(f3))) == 32'd0;
    endfunction

    // Extract size bytes at the addressed lane, sign-extending LB/LH.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int          sz   = ref_size(f3);
        int          lane = int'(addr % 32'd4);
        logic [63:0] mask = (64'd1 << (8 * sz)) - 64'd1;
        logic [63:0] v    = ({32'd0, word} >> (8 * lane)) & mask;
        if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store_data(input logic [2:0] f3, input logic [31:0] wd);
        int sz = ref_size(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic reset_model();
        ref_busy    = 1'b0;
        ref_err_cyc = 1'b0;
        ref_streak  = 0;
        resp_if     = 1'b0;
        resp_d      = 1'b0;
        resp_err    = 1'b0;
        resp_data   = 32'd0;
        last_if_gnt = 1'b0;
        last_d_gnt  = 1'b0;
    endtask

    // One clock cycle: inputs already driven; check grants, predict, clock, check.
    task automatic step();
        bit idle, exp_if, exp_d;
        bit n_if = 1'b0, n_d = 1'b0, n_err = 1'b0;
        logic [31:0] n_data = 32'd0;
        int sz, lane;
        #1;
        idle   = !ref_busy && !ref_err_cyc;
        exp_if = idle && if_req && (!d_req || ref_streak == MAX);
        exp_d  = idle && d_req && !exp_if;
        obs_d_gnt = d_gnt;
        check("if_gnt", if_gnt, exp_if);
        check("d_gnt", d_gnt, exp_d);
        last_if_gnt = exp_if;
        last_d_gnt  = exp_d;
        if (ref_err_cyc) begin
            ref_err_cyc = 1'b0;
        end else if (ref_busy) begin
            if (m_ack) begin
                ref_busy = 1'b0;
                n_data   = exp_fetch ? m_rdata :
                           (exp_store ? 32'd0 : ref_load(exp_f3, exp_addr, m_rdata));
                n_if     = exp_fetch;
                n_d      = !exp_fetch;
            end
        end else begin
            if (exp_if || !if_req) ref_streak = 0;
            else if (exp_d && ref_streak < MAX) ref_streak++;
            if (exp_if) begin
                gq.push_back(1'b1);
                ref_busy    = 1'b1;
                exp_fetch   = 1'b1;
                exp_m_addr  = if_addr & ~32'd3;
                exp_m_be    = 4'b1111;
                exp_m_we    = 1'b0;
            end else if (exp_d) begin
                gq.push_back(1'b0);
                if (!ref_legal(d_funct3, d_addr)) begin
                    ref_err_cyc = 1'b1;
                    n_d   = 1'b1;
                    n_err = 1'b1;
                end else begin
                    sz          = ref_size(d_funct3);
                    lane        = int'(d_addr % 32'd4);
                    ref_busy    = 1'b1;
                    exp_fetch   = 1'b0;
                    exp_store   = d_we;
                    exp_f3      = d_funct3;
                    exp_addr    = d_addr;
                    exp_m_addr  = d_addr - 32'(lane);
                    exp_m_we    = d_we;
                    exp_m_be    = d_we ? 4'(((1 << sz) - 1) << lane) : 4'b1111;
                    exp_m_wdata = ref_store_data(d_funct3, d_wdata);
                end
            end
        end
        @(posedge clk);
        #1;
        resp_if = n_if; resp_d = n_d; resp_err = n_err; resp_data = n_data;
        check("if_rvalid", if_rvalid, resp_if);
        check("d_rvalid", d_rvalid, resp_d);
        if (resp_d) begin
            check("d_rdata", d_rdata, resp_data);
            check("d_err", d_err, resp_err);
        end
        if (resp_if) check("if_rdata", if_rdata, resp_data);
        check("m_req", m_req, ref_busy);
        if (ref_busy) begin
            check("m_addr", m_addr, exp_m_addr);
            check("m_be", m_be, exp_m_be);
            check("m_we", m_we, exp_m_we);
            if (exp_m_we) check("m_wdata", m_wdata, exp_m_wdata);
        end
    endtask

    // One data access with single-cycle memory latency; returns what the DUT showed.
    task automatic data_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           output logic o_gnt, output logic o_mreq, output logic [31:0] o_addr,
                           output logic [3:0] o_be, output logic o_we, output logic [31:0] o_wd,
                           output logic o_rvalid, output logic [31:0] o_rdata, output logic o_err);
        bit legal = ref_legal(f3, addr);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        m_ack = 1'b0;
        step();
        o_gnt = obs_d_gnt;
        d_req = 1'b0;
        o_mreq = m_req; o_addr = m_addr; o_be = m_be; o_we = m_we; o_wd = m_wdata;
        if (legal) begin
            m_ack = 1'b1; m_rdata = rd;
            step();
            m_ack = 1'b0;
        end
        o_rvalid = d_rvalid; o_rdata = d_rdata; o_err = d_err;
        step();
    endtask

    task automatic drain();
        repeat (4) begin
            m_ack = ref_busy;
            step();
        end
        m_ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g, mr, w, rv, er;
        logic [31:0] a, wd, rdat;
        logic [3:0]  be;
        logic [31:0] order;

        // Reset with both requesters asserting.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0;
        d_funct3 = 3'd2; d_addr = 32'h0; d_wdata = 32'h0; m_ack = 1'b0; m_rdata = 32'h0;
        #2;
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_req", m_req, 0);
        check("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 0);
        check("rst_m_be", m_be, 0);
        check("rst_m_addr", m_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        rst = 1'b0;
        reset_model();

        // Plain LW.
        data_op(0, 3'd2, 32'h10, 32'h0, 32'hDEAD_BEEF, g, mr, a, be, w, wd, rv, rdat, er);
        check("lw_gnt", g, 1);
        check("lw_m_addr", a, 32'h10);
        check("lw_m_be", be, 4'b1111);
        check("lw_rvalid", rv, 1);
        check("lw_rdata", rdat, 32'hDEAD_BEEF);
        check("lw_err", er, 0);

        // Load formatting.
        data_op(0, 3'd0, 32'h3, 32'h0, 32'h80F1_7F02, g, mr, a, be, w, wd, rv, rdat, er);
        check("lb3", rdat, 32'hFFFF_FF80);
        data_op(0, 3'd4, 32'h3, 32'h0, 32'h80F1_7F02, g, mr, a, be, w, wd, rv, rdat, er);
        check("lbu3", rdat, 32'h0000_0080);
        data_op(0, 3'd1, 32'h2, 32'h0, 32'h80F1_7F02, g, mr, a, be, w, wd, rv, rdat, er);
        check("lh2", rdat, 32'hFFFF_80F1);
        data_op(0, 3'd5, 32'h0, 32'h0, 32'h80F1_7F02, g, mr, a, be, w, wd, rv, rdat, er);
        check("lhu0", rdat, 32'h0000_7F02);

        // Store steering.
        data_op(1, 3'd0, 32'h21, 32'hAB, 32'h0, g, mr, a, be, w, wd, rv, rdat, er);
        check("sb_m_addr", a, 32'h20);
        check("sb_m_be", be, 4'b0010);
        check("sb_m_wdata", wd, 32'hABAB_ABAB);
        check("sb_m_we", w, 1);
        check("sb_rdata", rdat, 0);
        data_op(1, 3'd1, 32'h22, 32'h1234, 32'h0, g, mr, a, be, w, wd, rv, rdat, er);
        check("sh_m_be", be, 4'b1100);
        check("sh_m_wdata", wd, 32'h1234_1234);

        // Misaligned LW and illegal funct3.
        data_op(0, 3'd2, 32'h6, 32'h0, 32'h0, g, mr, a, be, w, wd, rv, rdat, er);
        check("mis_m_req", mr, 0);
        check("mis_rvalid", rv, 1);
        check("mis_err", er, 1);
        check("mis_rdata", rdat, 0);
        data_op(0, 3'd7, 32'h8, 32'h0, 32'h0, g, mr, a, be, w, wd, rv, rdat, er);
        check("f3_7_m_req", mr, 0);
        check("f3_7_rvalid", rv, 1);
        check("f3_7_err", er, 1);

        // Starvation guard: both requesters held, ack latency 1.
        gq.delete();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h80;
        for (int c = 0; c < 20; c++) begin
            m_ack = ref_busy; m_rdata = $urandom;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        drain();
        order = 32'd0;
        for (int i = 0; i < 6; i++) if (i < gq.size() && gq[i]) order[i] = 1'b1;
        check("starve_len", 32'(gq.size() >= 6), 1);
        check("starve_order", order, 32'h10);

        // Reset mid-operation with a late ack.
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'h40; m_ack = 1'b0;
        step();
        check("pre_rst_m_req", m_req, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_m_req", m_req, 0);
        check("rst_mid_d_gnt", d_gnt, 0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h1111_2222;
        step();
        m_ack = 1'b0;
        check("late_ack_rvalid", d_rvalid, 0);
        data_op(0, 3'd2, 32'h44, 32'h0, 32'h0BAD_F00D, g, mr, a, be, w, wd, rv, rdat, er);
        check("post_rst_gnt", g, 1);
        check("post_rst_rdata", rdat, 32'h0BAD_F00D);

        // Randomized traffic; requests are held with stable fields until granted.
        for (int c = 0; c < 2000; c++) begin
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom_range(0, 99) < 35);
                if_addr = $urandom;
            end
            if (!d_req || last_d_gnt) begin
                d_req   = ($urandom_range(0, 99) < 55);
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom;
                d_wdata = $urandom;
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       d_funct3 = 3'd3;
                        1:       d_funct3 = 3'd6;
                        default: d_funct3 = 3'd7;
                    endcase
                end else if (d_we) begin
                    d_funct3 = 3'($urandom_range(0, 2));
                end else begin
                    case ($urandom_range(0, 4))
                        0:       d_funct3 = 3'd0;
                        1:       d_funct3 = 3'd1;
                        2:       d_funct3 = 3'd2;
                        3:       d_funct3 = 3'd4;
                        default: d_funct3 = 3'd5;
                    endcase
                end
                // Bias toward aligned addresses so most accesses reach memory.
                if ($urandom_range(0, 3) != 0) d_addr = d_addr & ~(32'(ref_size(d_funct3)) - 32'd1);
            end
            m_ack   = ref_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
            m_rdata = $urandom;
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
